// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only data memory.
// Sub-word stores are read-merge-write in a single cycle; loads are
// extracted by byte offset and sign/zero-extended.
// Build option: define LSU_MISALIGNED_EN to split misaligned H/W accesses
// into two word accesses (IDLE then SECOND). Without it, misaligned
// accesses are rejected with misalign_err in one cycle.
module load_store_unit #(
  parameter int ADDR_LSB_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        misalign_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

`ifdef LSU_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state;
  logic [31:0] first_word;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        op_ok;
  logic        misaligned;
  logic [1:0]  chk_off;
  logic [4:0]  sh;
  logic [3:0]  byte_mask;
  logic [31:0] bit_mask;
  logic [63:0] wide_mask;
  logic [63:0] wide_data;
  logic [63:0] wide_read;
  logic [31:0] raw;
  logic [31:0] ext_load;
  logic [31:0] lane_data;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic [29:0] next_word;

  // Decode size/sign, detect misalignment, and build the two-word views
  // used for load extraction and store lane merging.
  always_comb begin
    is_byte    = (funct3[1:0] == 2'b00);
    is_half    = (funct3[1:0] == 2'b01);
    is_word    = (funct3 == 3'b010);
    op_ok      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    chk_off    = (ADDR_LSB_CHECK != 0) ? addr[1:0] : 2'b00;
    misaligned = op_ok && ((is_half && chk_off[0]) || (is_word && (chk_off != 2'b00)));
    sh         = {addr[1:0], 3'b000};

    if (is_byte)      byte_mask = 4'b0001;
    else if (is_half) byte_mask = 4'b0011;
    else              byte_mask = 4'b1111;
    bit_mask  = {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};

    wide_mask = {32'h0, bit_mask} << sh;
    wide_data = {32'h0, store_data} << sh;
    wide_read = (state == SECOND) ? {mem_read_data, first_word} : {32'h0, mem_read_data};
    raw       = 32'(wide_read >> sh);

    if (is_byte)      ext_load = funct3[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
    else if (is_half) ext_load = funct3[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
    else              ext_load = raw;

    lane_data = (state == SECOND) ? wide_data[63:32] : wide_data[31:0];
    lane_mask = (state == SECOND) ? wide_mask[63:32] : wide_mask[31:0];
    merged    = (mem_read_data & ~lane_mask) | (lane_data & lane_mask);
    next_word = addr[31:2] + 30'd1;
  end

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    load_data      = 32'h0;
    done           = 1'b0;
    stall          = 1'b0;
    misalign_err   = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    mem_addr       = 32'h0;
    mem_write_data = 32'h0;
    if (rst_n) begin
      mem_addr       = (state == SECOND) ? {next_word, 2'b00} : {addr[31:2], 2'b00};
      mem_write_data = merged;
      if (state == SECOND) begin
        done      = 1'b1;
        MemRead   = 1'b1;
        MemWrite  = req_write;
        load_data = req_write ? 32'h0 : ext_load;
      end else if (req_valid) begin
        if (!op_ok) begin
          done = 1'b1;
        end else if (misaligned && !SPLIT_EN) begin
          done         = 1'b1;
          misalign_err = 1'b1;
        end else if (misaligned) begin
          stall    = 1'b1;
          MemRead  = 1'b1;
          MemWrite = req_write;
        end else begin
          done      = 1'b1;
          MemRead   = !req_write || !is_word;
          MemWrite  = req_write;
          load_data = req_write ? 32'h0 : ext_load;
        end
      end
    end
  end

  // Two-state split FSM; the first word is captured when a split starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      first_word <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (SPLIT_EN && req_valid && misaligned) begin
            state      <= SECOND;
            first_word <= mem_read_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, directed corner
// sequences and random transactions against a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        done;
  logic        stall;
  logic        misalign_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [16];
  logic        preload_en = 1'b0;
  logic [3:0]  preload_idx = 4'd0;
  logic [31:0] preload_val = 32'h0;

  logic [7:0]  ref_bytes [64];
  int          checks = 0;
  int          failures = 0;

`ifdef LSU_MISALIGNED_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic        write;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] exp_load;
    logic        exp_done;
    logic        exp_rd;
    logic        rd_care;
    string       name;
  } vec_t;

  vec_t vecs [10];

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data), .done(done), .stall(stall), .misalign_err(misalign_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (MemWrite) mem[mem_addr[5:2]] <= mem_write_data;
    else if (preload_en) mem[preload_idx] <= preload_val;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    req_write  = w;
    funct3     = f;
    addr       = a;
    store_data = d;
  endtask

  task automatic setWord(input int idx, input logic [31:0] val);
    preload_en  = 1'b1;
    preload_idx = idx[3:0];
    preload_val = val;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = val[8*i +: 8];
    @(posedge clk);
    #1;
    preload_en = 1'b0;
  endtask

  function automatic int sizeOf(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit opValid(input logic [2:0] f);
    return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
  endfunction

  function automatic bit isMisaligned(input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = sizeOf(f);
    if (!opValid(f)) return 1'b0;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] ba;
    int sz;
    sz = sizeOf(f);
    v = 32'h0;
    for (int i = 0; i < sz; i++) begin
      ba = a + i;
      v = v | ({24'h0, ref_bytes[ba[5:0]]} << (8*i));
    end
    if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 32'h1);
    return v;
  endfunction

  task automatic modelStore(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ba;
    for (int i = 0; i < sizeOf(f); i++) begin
      ba = a + i;
      ref_bytes[ba[5:0]] = d[8*i +: 8];
    end
  endtask

  task automatic compareMem(input string name);
    logic [31:0] exp;
    int bad;
    bad = -1;
    for (int w = 0; w < 16; w++) begin
      exp = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
      if (bad < 0 && mem[w] !== exp) bad = w;
    end
    if (bad < 0) bad = 0;
    exp = {ref_bytes[4*bad+3], ref_bytes[4*bad+2], ref_bytes[4*bad+1], ref_bytes[4*bad]};
    checkOutput($sformatf("%s mem[%0d]", name, bad), mem[bad], exp);
  endtask

  // One random transaction, checked against the byte-level model.
  task automatic randomTxn(input int n);
    logic        w;
    logic [2:0]  f;
    logic [31:0] a, d, exp_load;
    bit          ok, mis, split, err;
    w = 1'($urandom_range(0, 1));
    f = 3'($urandom_range(0, 7));
    a = $urandom;
    d = $urandom;
    ok    = opValid(f);
    mis   = isMisaligned(f, a);
    split = ok && mis && SPLIT;
    err   = ok && mis && !SPLIT;
    exp_load = (ok && !err && !w) ? modelLoad(f, a) : 32'h0;
    applyStimulus(1'b1, w, f, a, d);
    @(negedge clk);
    if (split) begin
      checkOutput($sformatf("rnd%0d c0 stall", n), {31'h0, stall}, 32'h1);
      checkOutput($sformatf("rnd%0d c0 done", n), {31'h0, done}, 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    checkOutput($sformatf("rnd%0d done", n), {31'h0, done}, 32'h1);
    checkOutput($sformatf("rnd%0d stall", n), {31'h0, stall}, 32'h0);
    checkOutput($sformatf("rnd%0d err", n), {31'h0, misalign_err}, {31'h0, err});
    checkOutput($sformatf("rnd%0d MemWrite", n), {31'h0, MemWrite}, {31'h0, ok && !err && w});
    checkOutput($sformatf("rnd%0d load_data", n), load_data, exp_load);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    if (ok && !err && w) modelStore(f, a, d);
    compareMem($sformatf("rnd%0d", n));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'b000, 32'h6, 32'hFFFFFF99, 1'b1, 1'b1, 1'b1, "LB_0x6"};
    vecs[1] = '{1'b1, 1'b0, 3'b100, 32'h6, 32'h00000099, 1'b1, 1'b1, 1'b1, "LBU_0x6"};
    vecs[2] = '{1'b1, 1'b0, 3'b001, 32'h4, 32'hFFFFAABB, 1'b1, 1'b1, 1'b1, "LH_0x4"};
    vecs[3] = '{1'b1, 1'b0, 3'b101, 32'h6, 32'h00008899, 1'b1, 1'b1, 1'b1, "LHU_0x6"};
    vecs[4] = '{1'b1, 1'b0, 3'b010, 32'h4, 32'h8899AABB, 1'b1, 1'b1, 1'b1, "LW_0x4"};
    vecs[5] = '{1'b1, 1'b0, 3'b000, 32'hB, 32'h00000011, 1'b1, 1'b1, 1'b1, "LB_0xB"};
    vecs[6] = '{1'b1, 1'b0, 3'b001, 32'hA, 32'h00001122, 1'b1, 1'b1, 1'b1, "LH_0xA"};
    vecs[7] = '{1'b1, 1'b0, 3'b011, 32'h4, 32'h00000000, 1'b1, 1'b0, 1'b0, "NOP_011"};
    vecs[8] = '{1'b1, 1'b1, 3'b111, 32'h8, 32'h00000000, 1'b1, 1'b0, 1'b0, "NOP_ST_111"};
    vecs[9] = '{1'b0, 1'b0, 3'b010, 32'h4, 32'h00000000, 1'b0, 1'b0, 1'b1, "IDLE_INVALID"};

    // Reset state: outputs forced low even with a valid request present.
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    #2;
    checkOutput("reset done", {31'h0, done}, 32'h0);
    checkOutput("reset stall", {31'h0, stall}, 32'h0);
    checkOutput("reset MemRead", {31'h0, MemRead}, 32'h0);
    checkOutput("reset load_data", load_data, 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) setWord(i, $urandom);
    setWord(1, 32'h8899AABB);
    setWord(2, 32'h11223344);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].write, vecs[i].f3, vecs[i].a, 32'hFFFF_FFFF);
      @(negedge clk);
      checkOutput({vecs[i].name, " done"}, {31'h0, done}, {31'h0, vecs[i].exp_done});
      checkOutput({vecs[i].name, " stall"}, {31'h0, stall}, 32'h0);
      checkOutput({vecs[i].name, " err"}, {31'h0, misalign_err}, 32'h0);
      checkOutput({vecs[i].name, " MemWrite"}, {31'h0, MemWrite}, 32'h0);
      checkOutput({vecs[i].name, " load_data"}, load_data, vecs[i].exp_load);
      if (vecs[i].rd_care) checkOutput({vecs[i].name, " MemRead"}, {31'h0, MemRead}, {31'h0, vecs[i].exp_rd});
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    end
    compareMem("after_table");

    // SH 0xBEEF at 0xA: read-merge-write in one cycle.
    applyStimulus(1'b1, 1'b1, 3'b001, 32'hA, 32'h0000BEEF);
    @(negedge clk);
    checkOutput("SH done", {31'h0, done}, 32'h1);
    checkOutput("SH stall", {31'h0, stall}, 32'h0);
    checkOutput("SH MemRead", {31'h0, MemRead}, 32'h1);
    checkOutput("SH MemWrite", {31'h0, MemWrite}, 32'h1);
    checkOutput("SH mem_write_data", mem_write_data, 32'hBEEF3344);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checkOutput("SH mem[2]", mem[2], 32'hBEEF3344);
    modelStore(3'b001, 32'hA, 32'h0000BEEF);

`ifdef LSU_MISALIGNED_EN
    // Split LW at 0x1, with req_valid dropped during SECOND.
    setWord(0, 32'h44332211);
    setWord(1, 32'h88776655);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h1, 32'h0);
    @(negedge clk);
    checkOutput("LWsplit c0 stall", {31'h0, stall}, 32'h1);
    checkOutput("LWsplit c0 done", {31'h0, done}, 32'h0);
    checkOutput("LWsplit c0 mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("LWsplit c1 done", {31'h0, done}, 32'h1);
    checkOutput("LWsplit c1 stall", {31'h0, stall}, 32'h0);
    checkOutput("LWsplit c1 mem_addr", mem_addr, 32'h4);
    checkOutput("LWsplit c1 load_data", load_data, 32'h55443322);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("LWsplit back idle", {31'h0, done}, 32'h0);

    // Reset while in SECOND, then an aligned LW must complete normally.
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h1, 32'h0);
    @(negedge clk);
    checkOutput("RST c0 stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("RST done", {31'h0, done}, 32'h0);
    checkOutput("RST stall", {31'h0, stall}, 32'h0);
    checkOutput("RST load_data", load_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("RST state idle", {31'h0, done}, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    @(negedge clk);
    checkOutput("RST LW done", {31'h0, done}, 32'h1);
    checkOutput("RST LW stall", {31'h0, stall}, 32'h0);
    checkOutput("RST LW load_data", load_data, 32'h88776655);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);

    // Split SW across the top of the address space wrapping to word 0.
    setWord(15, 32'h11112222);
    setWord(0, 32'hAAAA5555);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'hFFFFFFFE, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("SWwrap c0 stall", {31'h0, stall}, 32'h1);
    checkOutput("SWwrap c0 MemWrite", {31'h0, MemWrite}, 32'h1);
    checkOutput("SWwrap c0 mem_addr", mem_addr, 32'hFFFFFFFC);
    checkOutput("SWwrap c0 wdata", mem_write_data, 32'hBEEF2222);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("SWwrap c1 done", {31'h0, done}, 32'h1);
    checkOutput("SWwrap c1 mem_addr", mem_addr, 32'h0);
    checkOutput("SWwrap c1 wdata", mem_write_data, 32'hAAAADEAD);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    checkOutput("SWwrap mem[0]", mem[0], 32'hAAAADEAD);
    checkOutput("SWwrap mem[15]", mem[15], 32'hBEEF2222);
    modelStore(3'b010, 32'hFFFFFFFE, 32'hDEADBEEF);
`else
    // Misaligned accesses are rejected in one cycle with no memory change.
    setWord(0, 32'h01020304);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h2, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("SWmis err", {31'h0, misalign_err}, 32'h1);
    checkOutput("SWmis MemWrite", {31'h0, MemWrite}, 32'h0);
    checkOutput("SWmis done", {31'h0, done}, 32'h1);
    checkOutput("SWmis stall", {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h3, 32'h0);
    checkOutput("SWmis mem[0]", mem[0], 32'h01020304);
    @(negedge clk);
    checkOutput("LHmis err", {31'h0, misalign_err}, 32'h1);
    checkOutput("LHmis load_data", load_data, 32'h0);
    checkOutput("LHmis done", {31'h0, done}, 32'h1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
`endif
    compareMem("after_directed");

    // Random transactions against the byte-level model.
    for (int n = 0; n < 300; n++) randomTxn(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
